// File: rtl/vector_capture_monitor.sv
// Vector capture monitor: timestamps masked changes of a monitored vector into a FWFT FIFO.
// Optional trigger-armed start is compiled in with the VCM_TRIGGER_EN macro.
module vector_capture_monitor #(
   parameter int g_vec_bits   = 30,
   parameter int g_ts_bits    = 32,
   parameter int g_fifo_depth = 16
) (
   input  logic                          clk_sys_i,
   input  logic                          rst_i,
`ifdef VCM_TRIGGER_EN
   input  logic [g_vec_bits-1:0]         trig_val_i,
   output logic                          trig_o,
`endif
   input  logic [g_vec_bits-1:0]         vec_i,
   input  logic [g_vec_bits-1:0]         mask_i,
   input  logic                          arm_i,
   input  logic                          stop_i,
   input  logic                          rd_i,
   output logic                          rd_valid_o,
   output logic [g_ts_bits-1:0]          rd_ts_o,
   output logic [g_vec_bits-1:0]         rd_vec_o,
   output logic [$clog2(g_fifo_depth):0] count_o,
   output logic                          overflow_o,
   output logic [1:0]                    state_o
);

   localparam int AW = $clog2(g_fifo_depth);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(g_fifo_depth);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [g_ts_bits-1:0]  ts_cnt, ts_now;
   logic [g_vec_bits-1:0] prev_vec;
   logic                  change, trig_match, push_now;

   logic                  s1_valid, s2_valid;
   logic [g_ts_bits-1:0]  s1_ts, s2_ts;
   logic [g_vec_bits-1:0] s1_vec, s2_vec;

   logic [g_ts_bits+g_vec_bits-1:0] mem [g_fifo_depth];
   logic [AW:0]           wr_ptr, rd_ptr, count;
   logic                  empty, full, do_pop, do_wr;

   // ts_cnt holds the timestamp of the upcoming edge; the arm edge itself is ts 0.
   assign ts_now = arm_i ? '0 : ts_cnt;
   assign change = |((vec_i ^ prev_vec) & mask_i);

`ifdef VCM_TRIGGER_EN
   assign trig_match = ((vec_i ^ trig_val_i) & mask_i) == '0;
`else
   assign trig_match = 1'b0;
`endif

   always_ff @(posedge clk_sys_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         ts_cnt   <= '0;
         prev_vec <= '0;
      end else begin
         state    <= state_next;
         prev_vec <= vec_i;
         if (arm_i)
            ts_cnt <= g_ts_bits'(1);
         else if (ts_cnt != '1)
            ts_cnt <= ts_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      push_now   = 1'b0;
      if (arm_i) begin
`ifdef VCM_TRIGGER_EN
         state_next = S_ARMED;
`else
         state_next = S_CAPTURE;
         push_now   = 1'b1;
`endif
      end else begin
         case (state)
            S_CAPTURE: begin
               if (stop_i)
                  state_next = S_IDLE;
               else if (change)
                  push_now = 1'b1;
            end
            S_ARMED: begin
               if (stop_i) begin
                  state_next = S_IDLE;
               end else if (trig_match) begin
                  state_next = S_CAPTURE;
                  push_now   = 1'b1;
               end
            end
            S_IDLE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

`ifdef VCM_TRIGGER_EN
   // Only a trigger match moves ARMED to CAPTURE without arm_i.
   always_ff @(posedge clk_sys_i or posedge rst_i) begin
      if (rst_i)
         trig_o <= 1'b0;
      else
         trig_o <= (state == S_ARMED) && (state_next == S_CAPTURE);
   end
`endif

   // Two-stage entry pipeline; an arm edge kills anything still in flight.
   always_ff @(posedge clk_sys_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_ts    <= '0;
         s1_vec   <= '0;
         s2_valid <= 1'b0;
         s2_ts    <= '0;
         s2_vec   <= '0;
      end else begin
         s1_valid <= push_now;
         s1_ts    <= ts_now;
         s1_vec   <= vec_i;
         s2_valid <= s1_valid & ~arm_i;
         s2_ts    <= s1_ts;
         s2_vec   <= s1_vec;
      end
   end

   assign count  = wr_ptr - rd_ptr;
   assign empty  = (count == '0);
   assign full   = (count == DEPTH_C);
   assign do_pop = rd_i && !empty && !arm_i;
   assign do_wr  = s2_valid && (!full || do_pop) && !arm_i;

   always_ff @(posedge clk_sys_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_o <= 1'b0;
      end else if (arm_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (s2_valid && full && !do_pop)
            overflow_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (do_wr)
         mem[wr_ptr[AW-1:0]] <= {s2_ts, s2_vec};
   end

   // Head data is forced to zero while empty so reset and flush read back as zero.
   assign rd_valid_o = !empty;
   assign rd_ts_o    = empty ? '0 : mem[rd_ptr[AW-1:0]][g_ts_bits+g_vec_bits-1:g_vec_bits];
   assign rd_vec_o   = empty ? '0 : mem[rd_ptr[AW-1:0]][g_vec_bits-1:0];
   assign count_o    = count;
   assign state_o    = state;

endmodule

// File: tb/tb_vector_capture_monitor.sv
// Directed bench for vector_capture_monitor (depth 4); trigger cases build with VCM_TRIGGER_EN.
module tb_vector_capture_monitor;

   localparam int VB = 30;
   localparam int TB = 32;
   localparam int D  = 4;
   localparam int CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [VB-1:0] vec, mask;
   logic          arm, stop, rd;
   logic          rd_valid;
   logic [TB-1:0] rd_ts;
   logic [VB-1:0] rd_vec;
   logic [CW-1:0] count;
   logic          overflow;
   logic [1:0]    state;
`ifdef VCM_TRIGGER_EN
   logic [VB-1:0] trig_val;
   logic          trig;
`endif

   int n_vec  = 0;
   int n_miss = 0;
   int e      = 0;
   logic [TB+VB-1:0] exp_q[$];

   vector_capture_monitor #(
      .g_vec_bits  (VB),
      .g_ts_bits   (TB),
      .g_fifo_depth(D)
   ) dut (
      .clk_sys_i (clk),
      .rst_i     (rst),
`ifdef VCM_TRIGGER_EN
      .trig_val_i(trig_val),
      .trig_o    (trig),
`endif
      .vec_i     (vec),
      .mask_i    (mask),
      .arm_i     (arm),
      .stop_i    (stop),
      .rd_i      (rd),
      .rd_valid_o(rd_valid),
      .rd_ts_o   (rd_ts),
      .rd_vec_o  (rd_vec),
      .count_o   (count),
      .overflow_o(overflow),
      .state_o   (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic adv_to(input int k);
      while (e < k) step();
   endtask

   // Edge A is numbered 0.
   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
      e   = 0;
   endtask

   task automatic expect_entry(input logic [TB-1:0] ts, input logic [VB-1:0] v);
      exp_q.push_back({ts, v});
   endtask

   task automatic pop_check(input string tag);
      logic [TB+VB-1:0] x;
      x = exp_q.pop_front();
      check({tag, "_valid"}, 64'(rd_valid), 64'd1);
      check({tag, "_ts"},    64'(rd_ts),    64'(x[TB+VB-1:VB]));
      check({tag, "_vec"},   64'(rd_vec),   64'(x[VB-1:0]));
      rd = 1'b1;
      step();
      rd = 1'b0;
   endtask

   initial begin
      rst = 1'b1; vec = '0; mask = '1; arm = 1'b0; stop = 1'b0; rd = 1'b0;
`ifdef VCM_TRIGGER_EN
      trig_val = VB'(10);
`endif
      #22;
      check("rst_valid", 64'(rd_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_state", 64'(state), 64'd0);
      check("rst_ts", 64'(rd_ts), 64'd0);
      check("rst_vec", 64'(rd_vec), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

`ifdef VCM_TRIGGER_EN
      // trigger on vec == 10: first entry carries the match-edge timestamp
      do_arm();
      check("tg_armed", 64'(state), 64'd1);
      adv_to(21); vec = VB'(1);
      adv_to(51);
      check("tg_still_armed", 64'(state), 64'd1);
      check("tg_no_entry", 64'(count), 64'd0);
      vec = VB'(10);
      adv_to(52);
      check("tg_capture", 64'(state), 64'd2);
      check("tg_pulse", 64'(trig), 64'd1);
      adv_to(53);
      check("tg_pulse_end", 64'(trig), 64'd0);
      adv_to(54);
      check("tg_count", 64'(count), 64'd1);
      expect_entry(TB'(52), VB'(10));
      pop_check("tg_e0");
      vec = '0;
      stop = 1'b1; step(); stop = 1'b0;
`else
      // basic capture: baseline plus two changes, each landing two edges later
      do_arm();
      check("t1_state", 64'(state), 64'd2);
      check("t1_cnt_a0", 64'(count), 64'd0);
      adv_to(1);
      check("t1_cnt_a1", 64'(count), 64'd0);
      adv_to(2);
      check("t1_cnt_a2", 64'(count), 64'd1);
      adv_to(21); vec = VB'(1);
      adv_to(23);
      check("t1_cnt_a23", 64'(count), 64'd1);
      adv_to(24);
      check("t1_cnt_a24", 64'(count), 64'd2);
      adv_to(51); vec = VB'(10);
      adv_to(53);
      check("t1_cnt_a53", 64'(count), 64'd2);
      adv_to(54);
      check("t1_cnt_a54", 64'(count), 64'd3);
      expect_entry(TB'(0), VB'(0));
      expect_entry(TB'(22), VB'(1));
      expect_entry(TB'(52), VB'(10));
      pop_check("t1_e0");
      pop_check("t1_e1");
      pop_check("t1_e2");
      check("t1_empty", 64'(rd_valid), 64'd0);
`endif

      // mask 0x1: the 0->2 step is ignored, 2->3 is recorded
      mask = VB'(1); vec = '0;
      do_arm();
      adv_to(4); vec = VB'(2);
      adv_to(8); vec = VB'(3);
      adv_to(12);
      check("t2_count", 64'(count), 64'd2);
      if (state_expect_capture()) ;
      expect_entry(TB'(0), VB'(0));
      expect_entry(TB'(9), VB'(3));
      pop_check("t2_e0");
      pop_check("t2_e1");

      // overflow: 7 pushes into 4 slots keeps the first four
      mask = '1; vec = '0;
      do_arm();
      for (int k = 1; k <= 6; k++) begin
         vec = VB'(k);
         step();
      end
      adv_to(10);
      check("t3_count_full", 64'(count), 64'd4);
      check("t3_ovf_set", 64'(overflow), 64'd1);
      for (int k = 0; k < 4; k++) expect_entry(TB'(k), VB'(k));
      for (int k = 0; k < 4; k++) pop_check($sformatf("t3_e%0d", k));
      check("t3_ovf_sticky", 64'(overflow), 64'd1);
      vec = '0;
      do_arm();
      check("t3_ovf_clr", 64'(overflow), 64'd0);
      check("t3_flushed", 64'(count), 64'd0);

      // full FIFO with rd held: pop and push balance every edge
      for (int k = 1; k <= 5; k++) begin
         vec = VB'(k);
         step();
         if (k == 2) check("t3_rearm_cnt", 64'(count), 64'd1);
      end
      check("t4_full", 64'(count), 64'd4);
      rd = 1'b1;
      for (int k = 6; k <= 15; k++) begin
         vec = VB'(k);
         step();
         check($sformatf("t4_cnt_%0d", k), 64'(count), 64'd4);
         check($sformatf("t4_ovf_%0d", k), 64'(overflow), 64'd0);
         check($sformatf("t4_ts_%0d", k), 64'(rd_ts), 64'(k - 5));
      end
      rd = 1'b0;

      // asynchronous reset mid-capture with three entries held
      vec = '0;
      do_arm();
      vec = VB'(1); step();
      vec = VB'(2); step();
      adv_to(4);
      check("t5_count", 64'(count), 64'd3);
      #2 rst = 1'b1;
      #1;
      check("t5_valid", 64'(rd_valid), 64'd0);
      check("t5_cnt", 64'(count), 64'd0);
      check("t5_state", 64'(state), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

`ifndef VCM_TRIGGER_EN
      // arm beats stop on the same edge; a change at the stop edge is dropped
      mask = '1; vec = '0;
      arm = 1'b1; stop = 1'b1;
      step();
      arm = 1'b0; stop = 1'b0; e = 0;
      check("t6_arm_wins", 64'(state), 64'd2);
      vec = VB'(5); step();
      vec = VB'(6); stop = 1'b1; step(); stop = 1'b0;
      check("t6_idle", 64'(state), 64'd0);
      vec = VB'(7);
      adv_to(6);
      check("t6_count", 64'(count), 64'd2);
      expect_entry(TB'(0), VB'(0));
      expect_entry(TB'(1), VB'(5));
      pop_check("t6_e0");
      pop_check("t6_e1");
      rd = 1'b1; step(); rd = 1'b0;
      check("t6_empty_rd_cnt", 64'(count), 64'd0);
      check("t6_empty_rd_ts", 64'(rd_ts), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   function automatic bit state_expect_capture();
      return 1'b0;
   endfunction

endmodule

// File: doc/vector_capture_monitor.md
Name: vector_capture_monitor

Overview:
- Receive-side counterpart to the test-vector stimulus path of the bare module-test top.
- Samples the DUT output vector every clk_sys_i cycle and detects masked bit changes.
- Stores each change as a {timestamp, value} entry in an internal FIFO.
- Host logic or a bench drains the FIFO through a first-word-fall-through read handshake.

Parameters:
- g_vec_bits, 30: width of the monitored vector.
- g_ts_bits, 32: width of the cycle timestamp counter.
- g_fifo_depth, 16: FIFO entries; power of two, minimum 4.

Ports:
- clk_sys_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- vec_i  in  g_vec_bits  monitored vector (DUT output_vector), same clock domain.
- mask_i  in  g_vec_bits  1 = bit participates in change detection; sampled every cycle.
- arm_i  in  1  start or restart capture; level sampled per edge.
- stop_i  in  1  end capture; FIFO contents are kept.
- rd_i  in  1  pop head entry.
- rd_valid_o  out  1  FIFO not empty.
- rd_ts_o  out  g_ts_bits  head entry timestamp.
- rd_vec_o  out  g_vec_bits  head entry vector value.
- count_o  out  log2(g_fifo_depth)+1  entries held.
- overflow_o  out  1  sticky: an entry was dropped.
- state_o  out  2  0=IDLE, 1=ARMED, 2=CAPTURE.

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, rd_valid_o=0, rd_ts_o=0, rd_vec_o=0, count_o=0, overflow_o=0, ts counter=0.
- Timestamps are counted relative to arm edge A, the first edge at which arm_i=1 is sampled.
  - At A: FIFO flushed, overflow_o cleared, ts counter=0.
  - The vector value sampled at edge A+k carries ts=k.
  - ts saturates at 2^g_ts_bits-1 and does not wrap.
- Baseline entry: on entering CAPTURE, one entry is pushed with the current ts and the value sampled at that edge.
- Change entry: in CAPTURE, when ((vec at A+k) XOR (vec at A+k-1)) AND mask != 0, push {k, vec at A+k}. Unmasked bits are stored but never trigger a push.
- Latency: an entry sampled at edge A+k is visible on rd_* and counted in count_o after edge A+k+2. The pipeline is fixed at 2 stages.
- State machine:
  - IDLE -> CAPTURE on arm_i; goes to ARMED instead when VCM_TRIGGER_EN is defined.
  - CAPTURE -> IDLE on stop_i. Changes sampled at the stop edge and later are not recorded; entries already in the pipeline still land.
  - arm_i in any state restarts: flush and re-baseline.
  - arm_i and stop_i on the same edge: arm wins.
- Read, first-word-fall-through: rd_ts_o/rd_vec_o are valid whenever rd_valid_o=1. rd_i=1 with rd_valid_o=1 pops on that edge. rd_i while empty is ignored and has no effect.
- Full FIFO:
  - A push while full is dropped and overflow_o is set; overflow_o stays set until the next arm or reset.
  - Simultaneous pop and push while full: both occur, count unchanged, no overflow.
- A flush on the arm edge discards any pop requested on that same edge.
- Reset mid-capture: immediate return to reset values; all FIFO contents are lost.

Optional Feature:
- VCM_TRIGGER_EN defined:
  - Adds input trig_val_i [g_vec_bits] and output trig_o (1 cycle pulse).
  - arm_i enters ARMED. ARMED -> CAPTURE on the first edge where (vec AND mask) == (trig_val_i AND mask).
  - trig_o pulses in the cycle after that edge.
  - The baseline entry carries the ts of the match edge; ts keeps counting from arm during ARMED.
  - stop_i in ARMED -> IDLE.
- Not defined: no trig ports; ARMED is unreachable and state_o never reads 1.

Test Plan:
- Reset, then arm with vec=0 and mask=all ones; vec=1 at A+22, vec=10 at A+52 -> entries {0,0}, {22,1}, {52,10}; count_o=3; each entry appears 2 cycles after its edge.
- mask=0x1, vec 0 -> 2 -> 3 at A+5 and A+9 -> only the baseline and {9,3} are recorded.
- g_fifo_depth=4, 6 toggles with no reads -> count_o=4, overflow_o=1, entries hold the first 4 ts values. Re-arm -> overflow_o=0, count_o=1.
- FIFO full, rd_i held with a toggle every cycle -> count_o stays 4, overflow_o stays 0, ts values strictly increasing.
- Assert rst_i during CAPTURE with 3 entries held -> rd_valid_o=0, count_o=0, state_o=0 immediately (asynchronous).
- With VCM_TRIGGER_EN: trig_val=10, vec 0 -> 1 -> 10 -> state_o=1 until the match; trig_o pulses once; first entry is {52,10}.
